// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM receive path (pwm8adc1).
package pwm_pkg;

    typedef enum logic {
        SEARCH  = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam int WIDTH     = 8;
    localparam int FRAME_LEN = 1 << WIDTH;
    localparam int CODE_MAX  = FRAME_LEN - 1;

    // A frame that is high on every clock counts one past the largest code.
    function automatic int saturate(input int val, input int max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/pwm_in_sync.sv
// Input conditioning for the PWM line: 2-flop synchronizer, optional 3-sample
// majority filter (MAJORITY_FILTER_EN) and rising-edge detector.
module pwm_in_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sin,
    output logic s,
    output logic edge_pulse
);

    logic sync1_reg;
    logic sync2_reg;
    logic s_d_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= sin;
            sync2_reg <= sync1_reg;
        end
    end

`ifdef MAJORITY_FILTER_EN
    logic maj1_reg;
    logic maj2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maj1_reg <= 1'b0;
            maj2_reg <= 1'b0;
        end else begin
            maj1_reg <= sync2_reg;
            maj2_reg <= maj1_reg;
        end
    end

    // Both edges are delayed by one clock equally, so pulse widths are preserved.
    assign s = (sync2_reg & maj1_reg) | (sync2_reg & maj2_reg) | (maj1_reg & maj2_reg);
`else
    assign s = sync2_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_d_reg <= 1'b0;
        end else begin
            s_d_reg <= s;
        end
    end

    assign edge_pulse = s & ~s_d_reg;

endmodule

// File: rtl/pwm8adc1.sv
// PWM demodulator: recovers the per-frame high-clock count of a 2^width-clock
// PWM stream. Build with MAJORITY_FILTER_EN to reject single-clock glitches.
module pwm8adc1
    import pwm_pkg::*;
#(
    parameter int width = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    output logic [width-1:0] data_out,
    output logic             data_valid,
    output logic             locked,
    output logic             lock_lost
);

    localparam int                 CODE_TOP = (1 << width) - 1;
    localparam logic [width-1:0]   PHASE_LAST = {width{1'b1}};

    logic             s;
    logic             edge_pulse;
    state_t           state_reg;
    logic [width-1:0] tmo_reg;
    logic [width-1:0] phase_reg;
    logic [width:0]   acc_reg;
    logic [width:0]   acc_sum;

    pwm_in_sync u_in_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin        (sin),
        .s          (s),
        .edge_pulse (edge_pulse)
    );

    assign acc_sum = acc_reg + (width + 1)'(s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= SEARCH;
            tmo_reg    <= '0;
            phase_reg  <= '0;
            acc_reg    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            locked     <= 1'b0;
            lock_lost  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            lock_lost  <= 1'b0;
            case (state_reg)
                SEARCH: begin
                    locked <= 1'b0;
                    if (edge_pulse) begin
                        // The edge cycle is phase 0 and its sample is already high.
                        state_reg <= MEASURE;
                        locked    <= 1'b1;
                        phase_reg <= width'(1);
                        acc_reg   <= (width + 1)'(1);
                        tmo_reg   <= '0;
                    end else begin
                        tmo_reg <= tmo_reg + 1'b1;
                        if (tmo_reg == PHASE_LAST) begin
                            data_out   <= s ? {width{1'b1}} : '0;
                            data_valid <= 1'b1;
                        end
                    end
                end
                MEASURE: begin
                    locked <= 1'b1;
                    if (edge_pulse && (phase_reg != '0)) begin
                        // Re-align to the new edge and drop the partial frame.
                        lock_lost <= 1'b1;
                        phase_reg <= width'(1);
                        acc_reg   <= (width + 1)'(1);
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                        if (phase_reg == PHASE_LAST) begin
                            data_out   <= width'(saturate(int'(acc_sum), CODE_TOP));
                            data_valid <= 1'b1;
                            acc_reg    <= '0;
                        end else begin
                            acc_reg <= acc_sum;
                        end
                    end
                end
                default: begin
                    state_reg <= SEARCH;
                    locked    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm8adc1.sv
// Self-checking bench for pwm8adc1: DAC-style PWM frames in, scoreboard of
// expected codes popped on every data_valid.
`timescale 1ns/1ps
module tb_pwm8adc1;

    localparam int FRAME = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sin = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       locked;
    logic       lock_lost;

    int         n_checks = 0;
    int         n_fail = 0;
    int         lost_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    pwm8adc1 #(.width(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin        (sin),
        .data_out   (data_out),
        .data_valid (data_valid),
        .locked     (locked),
        .lock_lost  (lock_lost)
    );

    // One clock of stimulus; outputs are sampled on the falling edge and any
    // valid word is popped against the scoreboard.
    task automatic step(input logic v);
        logic [7:0] e;
        @(posedge clk);
        #1 sin = v;
        @(negedge clk);
        if (lock_lost === 1'b1) lost_cnt++;
        if (data_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_valid: data_out=%0d, required no valid", data_out);
            end else begin
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    n_fail++;
                    $display("FAIL sb_data: data_out=%0d, required %0d", data_out, e);
                end else begin
                    $display("valid data_out=%0d ok", data_out);
                end
            end
        end
    endtask

    task automatic drive_frame(input int code, input int len);
        for (int p = 0; p < len; p++) step(p < code);
    endtask

    task automatic start_test();
        rst_n = 1'b0;
        sin   = 1'b0;
        exp_q.delete();
        lost_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (data_out !== 8'd0) begin n_fail++; $display("FAIL reset_data_out: got %0d, required 0", data_out); end
        n_checks++;
        if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b, required 0", data_valid); end
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b, required 0", locked); end
        n_checks++;
        if (lock_lost !== 1'b0) begin n_fail++; $display("FAIL reset_lock_lost: got %b, required 0", lock_lost); end
        $display("reset outputs checked");
    endtask

    task automatic test_code128();
        start_test();
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL c128_search_locked: got %b, required 0", locked); end
        for (int f = 0; f < 4; f++) begin
            exp_q.push_back(8'd128);
            drive_frame(128, FRAME);
        end
        for (int i = 0; i < 8; i++) step(1'b0);
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL c128_missing: %0d valids outstanding, required 0", exp_q.size()); end
        n_checks++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL c128_locked: got %b, required 1", locked); end
        n_checks++;
        if (lost_cnt != 0) begin n_fail++; $display("FAIL c128_lock_lost: got %0d pulses, required 0", lost_cnt); end
    endtask

    task automatic test_idle_low();
        start_test();
        for (int i = 0; i < 3; i++) exp_q.push_back(8'd0);
        for (int i = 0; i < 800; i++) step(1'b0);
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL low_missing: %0d valids outstanding, required 0", exp_q.size()); end
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL low_locked: got %b, required 0", locked); end
    endtask

    task automatic test_code255_saturate();
        start_test();
        for (int f = 0; f < 3; f++) begin
            exp_q.push_back(8'd255);
            drive_frame(255, FRAME);
        end
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back(8'd255);
            drive_frame(FRAME, FRAME);
        end
        for (int i = 0; i < 8; i++) step(1'b1);
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL c255_missing: %0d valids outstanding, required 0", exp_q.size()); end
        n_checks++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL c255_locked: got %b, required 1", locked); end
        n_checks++;
        if (lost_cnt != 0) begin n_fail++; $display("FAIL c255_lock_lost: got %0d pulses, required 0", lost_cnt); end
    endtask

    task automatic test_misaligned();
        start_test();
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back(8'd64);
            drive_frame(64, FRAME);
        end
        // A new frame starts at phase 100 of the third: that frame is dropped.
        drive_frame(64, 100);
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back(8'd64);
            drive_frame(64, FRAME);
        end
        for (int i = 0; i < 8; i++) step(1'b0);
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL mis_missing: %0d valids outstanding, required 0", exp_q.size()); end
        n_checks++;
        if (lost_cnt != 1) begin n_fail++; $display("FAIL mis_lock_lost: got %0d pulses, required 1", lost_cnt); end
        n_checks++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL mis_locked: got %b, required 1", locked); end
    endtask

    task automatic test_reset_midframe();
        start_test();
        exp_q.push_back(8'd200);
        drive_frame(200, FRAME);
        drive_frame(200, 130);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (data_out !== 8'd0) begin n_fail++; $display("FAIL midrst_data_out: got %0d, required 0", data_out); end
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL midrst_locked: got %b, required 0", locked); end
        n_checks++;
        if ((data_valid !== 1'b0) || (lock_lost !== 1'b0)) begin
            n_fail++;
            $display("FAIL midrst_pulses: valid=%b lost=%b, required 0 0", data_valid, lock_lost);
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL midrst_first_frame: %0d valids outstanding, required 0", exp_q.size()); end
        sin = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0);
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back(8'd200);
            drive_frame(200, FRAME);
        end
        for (int i = 0; i < 8; i++) step(1'b0);
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL midrst_missing: %0d valids outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_glitch();
        int exp_lost;
        start_test();
`ifdef MAJORITY_FILTER_EN
        exp_lost = 0;
        for (int i = 0; i < 3; i++) exp_q.push_back(8'd50);
`else
        // Glitch at 150 and the following frame start each land misaligned.
        exp_lost = 5;
`endif
        for (int f = 0; f < 3; f++) begin
            for (int p = 0; p < FRAME; p++) step((p < 50) || (p == 150));
        end
        for (int i = 0; i < 8; i++) step(1'b0);
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL glitch_missing: %0d valids outstanding, required 0", exp_q.size()); end
        n_checks++;
        if (lost_cnt != exp_lost) begin n_fail++; $display("FAIL glitch_lock_lost: got %0d pulses, required %0d", lost_cnt, exp_lost); end
    endtask

    initial begin
        test_reset();
        test_code128();
        test_idle_low();
        test_code255_saturate();
        test_misaligned();
        test_reset_midframe();
        test_glitch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
